// File: rtl/lsu_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_ctrl_if
// Bundle of every non-clock/reset signal of the load/store sequencer.
//   Issue side : issue_valid/issue_ready handshake plus decoded op fields
//                (is_load, is_store, func3, base, offset, store_data, dest_i).
//   Memory bus : mem_req/mem_ack handshake with mem_we, mem_addr, mem_wdata,
//                mem_wstrb and mem_rdata.
//   Write-back : result, dest_o, result_valid, plus busy/timeout/misaligned
//                status towards the pipeline.
// Modports
//   slave  : the LSU itself (consumes issue ops, masters the memory bus).
//   master : the surrounding pipeline + data memory.
// ---------------------------------------------------------------------------
interface lsu_ctrl_if;
   logic        issue_valid;
   logic        issue_ready;
   logic        is_load;
   logic        is_store;
   logic [2:0]  func3;
   logic [31:0] base;
   logic [31:0] offset;
   logic [31:0] store_data;
   logic [4:0]  dest_i;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   logic [31:0] result;
   logic [4:0]  dest_o;
   logic        result_valid;
   logic        busy;
   logic        timeout;
   logic        misaligned;

   modport slave (
      input  issue_valid, is_load, is_store, func3, base, offset, store_data, dest_i,
      input  mem_ack, mem_rdata,
      output issue_ready,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      output result, dest_o, result_valid, busy, timeout, misaligned
   );

   modport master (
      output issue_valid, is_load, is_store, func3, base, offset, store_data, dest_i,
      output mem_ack, mem_rdata,
      input  issue_ready,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
      input  result, dest_o, result_valid, busy, timeout, misaligned
   );
endinterface

// File: rtl/lsu_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_ctrl
// Load/store sequencer beside the execute stage. Accepts one decoded load or
// store, forms base+offset, runs a single req/ack access on the data-memory
// bus and returns sign/zero-extended load data. busy stalls the pipeline for
// the whole access; an access with no mem_ack for TIMEOUT_CYCLES is aborted.
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : lsu_ctrl_if.slave (issue handshake, memory bus, write-back)
// Parameters
//   TIMEOUT_CYCLES : REQ cycles without mem_ack before abort (>= 1)
// Configuration
//   LSU_MISALIGN_TRAP_EN : when defined, misaligned half/word ops are rejected
//   without a bus cycle and flagged on misaligned; when undefined the address
//   is aligned down and the access proceeds.
// ---------------------------------------------------------------------------
module lsu_ctrl #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input logic       clk,
   input logic       reset,
   lsu_ctrl_if.slave bus
);
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   logic [1:0]       r_state;
   logic [31:0]      r_addr;
   logic [31:0]      r_wdata;
   logic [3:0]       r_wstrb;
   logic             r_we;
   logic             r_load;
   logic             r_unsigned;
   logic [1:0]       r_size;
   logic [4:0]       r_dest;
   logic [31:0]      r_result;
   logic             r_to;
   logic [CNT_W-1:0] r_cnt;

   logic        w_accept;
   logic [31:0] w_ea;
   logic [31:0] w_addr;
   logic [1:0]  w_size;
   logic [31:0] w_wdata;
   logic [3:0]  w_wstrb;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_ldata;
   logic        w_done;
   logic        w_ok;

   assign w_accept = (r_state == ST_IDLE) && bus.issue_valid && (bus.is_load ^ bus.is_store);
   assign w_ea     = bus.base + bus.offset;

   // Stores only know b/h/w; any other func3 on a store is a full word.
   always_comb begin
      w_size = SZ_W;
      if (bus.is_load) begin
         case (bus.func3)
            3'b000, 3'b100: w_size = SZ_B;
            3'b001, 3'b101: w_size = SZ_H;
            default:        w_size = SZ_W;
         endcase
      end else begin
         case (bus.func3)
            3'b000:  w_size = SZ_B;
            3'b001:  w_size = SZ_H;
            default: w_size = SZ_W;
         endcase
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic r_mis;
   logic w_misalign;

   assign w_misalign = ((w_size == SZ_H) && w_ea[0]) ||
                       ((w_size == SZ_W) && (w_ea[1:0] != 2'b00));
   assign w_addr     = w_ea;
`else
   // Without the trap, misaligned halves/words silently align down.
   always_comb begin
      w_addr = w_ea;
      if (w_size == SZ_H) begin
         w_addr[0] = 1'b0;
      end else if (w_size == SZ_W) begin
         w_addr[1:0] = 2'b00;
      end
   end
`endif

   // Store lane steering: data replicated to every lane, strobes pick the lanes.
   always_comb begin
      case (w_size)
         SZ_B: begin
            w_wstrb = 4'b0001 << w_addr[1:0];
            w_wdata = {4{bus.store_data[7:0]}};
         end
         SZ_H: begin
            w_wstrb = 4'b0011 << {w_addr[1], 1'b0};
            w_wdata = {2{bus.store_data[15:0]}};
         end
         default: begin
            w_wstrb = 4'b1111;
            w_wdata = bus.store_data;
         end
      endcase
   end

   // Load lane extraction and extension from the latched address/size.
   assign w_byte = bus.mem_rdata[8*r_addr[1:0] +: 8];
   assign w_half = bus.mem_rdata[16*r_addr[1] +: 16];

   always_comb begin
      case (r_size)
         SZ_B:    w_ldata = r_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
         SZ_H:    w_ldata = r_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_ldata = bus.mem_rdata;
      endcase
   end

   // Sequencer: IDLE latches the op, REQ holds the bus until ack or timeout,
   // DONE presents the outcome for exactly one cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_we       <= 1'b0;
         r_load     <= 1'b0;
         r_unsigned <= 1'b0;
         r_size     <= SZ_B;
         r_dest     <= '0;
         r_result   <= '0;
         r_to       <= 1'b0;
         r_cnt      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         r_mis      <= 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_addr     <= w_addr;
                  r_wdata    <= bus.is_store ? w_wdata : 32'b0;
                  r_wstrb    <= bus.is_store ? w_wstrb : 4'b0000;
                  r_we       <= bus.is_store;
                  r_load     <= bus.is_load;
                  r_unsigned <= bus.func3[2];
                  r_size     <= w_size;
                  r_dest     <= bus.dest_i;
                  r_to       <= 1'b0;
                  r_cnt      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
                  r_mis      <= w_misalign;
                  r_state    <= w_misalign ? ST_DONE : ST_REQ;
`else
                  r_state    <= ST_REQ;
`endif
               end
            end
            ST_REQ: begin
               // Ack is checked first so an ack on the last allowed cycle wins.
               if (bus.mem_ack) begin
                  r_result <= w_ldata;
                  r_state  <= ST_DONE;
               end else if (r_cnt == CNT_LAST) begin
                  r_result <= '0;
                  r_to     <= 1'b1;
                  r_state  <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign w_done = (r_state == ST_DONE);

`ifdef LSU_MISALIGN_TRAP_EN
   assign w_ok           = !r_to && !r_mis;
   assign bus.misaligned = w_done && r_mis;
`else
   assign w_ok           = !r_to;
   assign bus.misaligned = 1'b0;
`endif

   // issue_ready is also gated by reset so it reads 0 while reset is held.
   assign bus.issue_ready  = (r_state == ST_IDLE) && reset;
   assign bus.mem_req      = (r_state == ST_REQ);
   assign bus.mem_we       = bus.mem_req && r_we;
   assign bus.mem_addr     = r_addr;
   assign bus.mem_wdata    = r_wdata;
   assign bus.mem_wstrb    = bus.mem_req ? r_wstrb : 4'b0000;
   assign bus.busy         = (r_state != ST_IDLE);
   assign bus.timeout      = w_done && r_to;
   assign bus.result_valid = w_done && r_load && w_ok;
   assign bus.result       = bus.result_valid ? r_result : 32'b0;
   assign bus.dest_o       = bus.result_valid ? r_dest : 5'b0;
endmodule

// File: tb/tb_lsu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lsu_ctrl
// Scoreboard bench for lsu_ctrl with TIMEOUT_CYCLES=4. Each issued op pushes
// its expected bus request and its expected completion; a monitor pops and
// compares them as the DUT raises mem_req and reaches its completion cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsu_ctrl;
   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } busExp_t;

   typedef struct {
      logic        rv;
      logic [31:0] result;
      logic [4:0]  dest;
      logic        to;
      logic        mis;
      int          reqCycles;
   } respExp_t;

   logic clock;
   logic reset;

   lsu_ctrl_if lsuBus();

   lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk   (clock),
      .reset (reset),
      .bus   (lsuBus)
   );

   int checkCount = 0;
   int errorCount = 0;

   busExp_t  busQ[$];
   respExp_t respQ[$];

   int          ackDelay  = 0;
   bit          noAck     = 1'b0;
   logic [31:0] rdataVal  = '0;

   // Free-running 10 ns clock.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   // Memory responder: acks after ackDelay REQ cycles unless noAck is set.
   // Outside the ack cycle rdata carries a wrong value to catch early sampling.
   int reqCnt = 0;
   initial begin
      lsuBus.mem_ack   = 1'b0;
      lsuBus.mem_rdata = '0;
      forever begin
         @(posedge clock);
         #1;
         if (reset && lsuBus.mem_req) begin
            if (!noAck && reqCnt == ackDelay) begin
               lsuBus.mem_ack   = 1'b1;
               lsuBus.mem_rdata = rdataVal;
            end else begin
               lsuBus.mem_ack   = 1'b0;
               lsuBus.mem_rdata = ~rdataVal;
            end
            reqCnt++;
         end else begin
            lsuBus.mem_ack   = 1'b0;
            lsuBus.mem_rdata = ~rdataVal;
            reqCnt           = 0;
         end
      end
   end

   // Monitor: checks the bus request against the scoreboard when mem_req rises,
   // keeps the address under watch while it is held, and checks the completion
   // cycle (busy with no request outstanding) against the response queue.
   bit       inReq     = 1'b0;
   bit       doneSeen  = 1'b0;
   int       reqCycles = 0;
   busExp_t  curBus;
   respExp_t curResp;

   always @(negedge clock) begin
      if (!reset) begin
         inReq     = 1'b0;
         doneSeen  = 1'b0;
         reqCycles = 0;
      end else begin
         if (doneSeen) begin
            checkOutput("readyAfterDone", 32'(lsuBus.issue_ready), 32'd1);
            checkOutput("pulseOneCycle", 32'(lsuBus.result_valid | lsuBus.timeout), 32'd0);
            doneSeen = 1'b0;
         end
         if (lsuBus.mem_req) begin
            if (!inReq) begin
               if (busQ.size() == 0) begin
                  checkOutput("unexpectedReq", 32'd1, 32'd0);
               end else begin
                  curBus = busQ.pop_front();
                  checkOutput("memAddr", lsuBus.mem_addr, curBus.addr);
                  checkOutput("memWe", 32'(lsuBus.mem_we), 32'(curBus.we));
                  checkOutput("memWstrb", 32'(lsuBus.mem_wstrb), 32'(curBus.strb));
                  if (curBus.we) begin
                     checkOutput("memWdata", lsuBus.mem_wdata, curBus.wdata);
                  end
               end
            end else begin
               checkOutput("addrStable", lsuBus.mem_addr, curBus.addr);
            end
            inReq = 1'b1;
            reqCycles++;
         end else begin
            inReq = 1'b0;
         end
         if (lsuBus.busy && !lsuBus.mem_req) begin
            if (respQ.size() == 0) begin
               checkOutput("unexpectedDone", 32'd1, 32'd0);
            end else begin
               curResp = respQ.pop_front();
               checkOutput("resultValid", 32'(lsuBus.result_valid), 32'(curResp.rv));
               checkOutput("result", lsuBus.result, curResp.result);
               checkOutput("destO", 32'(lsuBus.dest_o), 32'(curResp.dest));
               checkOutput("timeout", 32'(lsuBus.timeout), 32'(curResp.to));
               checkOutput("misaligned", 32'(lsuBus.misaligned), 32'(curResp.mis));
               checkOutput("reqCycles", 32'(reqCycles), 32'(curResp.reqCycles));
               checkOutput("readyInDone", 32'(lsuBus.issue_ready), 32'd0);
            end
            reqCycles = 0;
            doneSeen  = 1'b1;
         end
      end
   end

   // Offers one op, records its expectations and waits for it to retire.
   task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] b, input logic [31:0] off,
                                input logic [31:0] sd, input logic [4:0] dst,
                                input int delay, input bit noAckIn,
                                input logic [31:0] rd, input bit expBus,
                                input busExp_t eb, input respExp_t er);
      int n;
      n = 0;
      @(negedge clock);
      while (!lsuBus.issue_ready && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!lsuBus.issue_ready) begin
         checkOutput("issueReadyWait", 32'(lsuBus.issue_ready), 32'd1);
         return;
      end
      ackDelay = delay;
      noAck    = noAckIn;
      rdataVal = rd;
      if (expBus) busQ.push_back(eb);
      respQ.push_back(er);
      lsuBus.is_load     = ld;
      lsuBus.is_store    = st;
      lsuBus.func3       = f3;
      lsuBus.base        = b;
      lsuBus.offset      = off;
      lsuBus.store_data  = sd;
      lsuBus.dest_i      = dst;
      lsuBus.issue_valid = 1'b1;
      @(posedge clock);
      #1;
      lsuBus.issue_valid = 1'b0;
      checkOutput("busyAfterAccept", 32'(lsuBus.busy), 32'd1);
      n = 0;
      @(negedge clock);
      while (lsuBus.busy && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (lsuBus.busy) begin
         checkOutput("retireWait", 32'(lsuBus.busy), 32'd0);
      end
   endtask

   // Offers an op with an illegal load/store combination; it must be ignored.
   task automatic applyIgnored(input string tag, input logic ld, input logic st);
      @(negedge clock);
      lsuBus.is_load     = ld;
      lsuBus.is_store    = st;
      lsuBus.func3       = 3'b010;
      lsuBus.base        = 32'h0000_0700;
      lsuBus.offset      = '0;
      lsuBus.issue_valid = 1'b1;
      @(posedge clock);
      #1;
      lsuBus.issue_valid = 1'b0;
      checkOutput(tag, 32'(lsuBus.busy | lsuBus.mem_req), 32'd0);
   endtask

   logic [7:0]  laneData;
   logic [31:0] laneWord;

   initial begin
      reset              = 1'b0;
      lsuBus.issue_valid = 1'b0;
      lsuBus.is_load     = 1'b0;
      lsuBus.is_store    = 1'b0;
      lsuBus.func3       = '0;
      lsuBus.base        = '0;
      lsuBus.offset      = '0;
      lsuBus.store_data  = '0;
      lsuBus.dest_i      = '0;

      repeat (3) @(negedge clock);
      checkOutput("rstIssueReady", 32'(lsuBus.issue_ready), 32'd0);
      checkOutput("rstBusy", 32'(lsuBus.busy), 32'd0);
      checkOutput("rstMemReq", 32'(lsuBus.mem_req), 32'd0);
      checkOutput("rstResult", lsuBus.result | 32'(lsuBus.result_valid), 32'd0);
      checkOutput("rstStatus", 32'({lsuBus.timeout, lsuBus.misaligned, lsuBus.dest_o}), 32'd0);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("idleIssueReady", 32'(lsuBus.issue_ready), 32'd1);

      // lw 0x100+4, ack two cycles after request
      applyStimulus(1, 0, 3'b010, 32'h100, 32'h4, 32'h0, 5'd5, 2, 0, 32'hDEADBEEF, 1,
         busExp_t'{32'h104, 1'b0, 4'b0000, 32'h0},
         respExp_t'{1'b1, 32'hDEADBEEF, 5'd5, 1'b0, 1'b0, 3});
      // lb / lbu on the top byte lane
      applyStimulus(1, 0, 3'b000, 32'h200, 32'h3, 32'h0, 5'd7, 0, 0, 32'h80123456, 1,
         busExp_t'{32'h203, 1'b0, 4'b0000, 32'h0},
         respExp_t'{1'b1, 32'hFFFFFF80, 5'd7, 1'b0, 1'b0, 1});
      applyStimulus(1, 0, 3'b100, 32'h200, 32'h3, 32'h0, 5'd8, 1, 0, 32'h80123456, 1,
         busExp_t'{32'h203, 1'b0, 4'b0000, 32'h0},
         respExp_t'{1'b1, 32'h00000080, 5'd8, 1'b0, 1'b0, 2});
      // lh upper half / lhu lower half
      applyStimulus(1, 0, 3'b001, 32'h200, 32'h2, 32'h0, 5'd9, 0, 0, 32'h80123456, 1,
         busExp_t'{32'h202, 1'b0, 4'b0000, 32'h0},
         respExp_t'{1'b1, 32'hFFFF8012, 5'd9, 1'b0, 1'b0, 1});
      applyStimulus(1, 0, 3'b101, 32'h1FC, 32'h4, 32'h0, 5'd10, 0, 0, 32'h8012B456, 1,
         busExp_t'{32'h200, 1'b0, 4'b0000, 32'h0},
         respExp_t'{1'b1, 32'h0000B456, 5'd10, 1'b0, 1'b0, 1});
      // lw with negative offset and address wrap, dest 0 still pulses
      applyStimulus(1, 0, 3'b010, 32'h10, 32'hFFFFFFF4, 32'h0, 5'd0, 1, 0, 32'h13579BDF, 1,
         busExp_t'{32'h4, 1'b0, 4'b0000, 32'h0},
         respExp_t'{1'b1, 32'h13579BDF, 5'd0, 1'b0, 1'b0, 2});
      // sh at 0x102
      applyStimulus(0, 1, 3'b001, 32'h100, 32'h2, 32'h1234ABCD, 5'd9, 1, 0, 32'h0, 1,
         busExp_t'{32'h102, 1'b1, 4'b1100, 32'hABCDABCD},
         respExp_t'{1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2});
      // sw, and a store with func3=hu which acts as a word
      applyStimulus(0, 1, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 5'd3, 0, 0, 32'h0, 1,
         busExp_t'{32'h300, 1'b1, 4'b1111, 32'hCAFEF00D},
         respExp_t'{1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1});
      applyStimulus(0, 1, 3'b101, 32'h500, 32'h0, 32'h89ABCDEF, 5'd4, 0, 0, 32'h0, 1,
         busExp_t'{32'h500, 1'b1, 4'b1111, 32'h89ABCDEF},
         respExp_t'{1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1});
      // sb and lbu across all four byte lanes
      for (int i = 0; i < 4; i++) begin
         laneData = 8'hA0 + 8'(i);
         applyStimulus(0, 1, 3'b000, 32'h400, 32'(i), {24'h123456, laneData}, 5'd1, 0, 0, 32'h0, 1,
            busExp_t'{32'h400 + 32'(i), 1'b1, 4'b0001 << i, {4{laneData}}},
            respExp_t'{1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1});
         laneWord = 32'h11 * 32'(i + 1);
         applyStimulus(1, 0, 3'b100, 32'h400, 32'(i), 32'h0, 5'd2, 0, 0, 32'h44332211, 1,
            busExp_t'{32'h400 + 32'(i), 1'b0, 4'b0000, 32'h0},
            respExp_t'{1'b1, laneWord, 5'd2, 1'b0, 1'b0, 1});
      end
      // No ack: four REQ cycles then a timeout pulse
      applyStimulus(1, 0, 3'b010, 32'h600, 32'h0, 32'h0, 5'd6, 0, 1, 32'h0, 1,
         busExp_t'{32'h600, 1'b0, 4'b0000, 32'h0},
         respExp_t'{1'b0, 32'h0, 5'd0, 1'b1, 1'b0, 4});
      // Ack on the fourth REQ cycle still completes normally
      applyStimulus(1, 0, 3'b010, 32'h600, 32'h0, 32'h0, 5'd6, 3, 0, 32'h0BADF00D, 1,
         busExp_t'{32'h600, 1'b0, 4'b0000, 32'h0},
         respExp_t'{1'b1, 32'h0BADF00D, 5'd6, 1'b0, 1'b0, 4});
`ifdef LSU_MISALIGN_TRAP_EN
      applyStimulus(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 5'd5, 0, 0, 32'h0, 0,
         busExp_t'{32'h0, 1'b0, 4'b0000, 32'h0},
         respExp_t'{1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 0});
      applyStimulus(0, 1, 3'b001, 32'h103, 32'h0, 32'h1234ABCD, 5'd5, 0, 0, 32'h0, 0,
         busExp_t'{32'h0, 1'b0, 4'b0000, 32'h0},
         respExp_t'{1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 0});
`else
      applyStimulus(1, 0, 3'b010, 32'h101, 32'h0, 32'h0, 5'd5, 0, 0, 32'h55AA55AA, 1,
         busExp_t'{32'h100, 1'b0, 4'b0000, 32'h0},
         respExp_t'{1'b1, 32'h55AA55AA, 5'd5, 1'b0, 1'b0, 1});
      applyStimulus(0, 1, 3'b001, 32'h103, 32'h0, 32'h1234ABCD, 5'd5, 0, 0, 32'h0, 1,
         busExp_t'{32'h102, 1'b1, 4'b1100, 32'hABCDABCD},
         respExp_t'{1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1});
`endif
      // Illegal load/store combinations are ignored
      applyIgnored("ignoreBoth", 1'b1, 1'b1);
      applyIgnored("ignoreNeither", 1'b0, 1'b0);

      // Reset in the middle of a REQ
      @(negedge clock);
      noAck = 1'b1;
      busQ.push_back(busExp_t'{32'h800, 1'b0, 4'b0000, 32'h0});
      lsuBus.is_load     = 1'b1;
      lsuBus.is_store    = 1'b0;
      lsuBus.func3       = 3'b010;
      lsuBus.base        = 32'h800;
      lsuBus.offset      = 32'h0;
      lsuBus.issue_valid = 1'b1;
      @(posedge clock);
      #1;
      lsuBus.issue_valid = 1'b0;
      @(posedge clock);
      #3;
      checkOutput("reqBeforeReset", 32'(lsuBus.mem_req), 32'd1);
      reset = 1'b0;
      #1;
      checkOutput("midRstMemReq", 32'(lsuBus.mem_req), 32'd0);
      checkOutput("midRstBusy", 32'(lsuBus.busy), 32'd0);
      checkOutput("midRstIssueReady", 32'(lsuBus.issue_ready), 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      applyStimulus(0, 1, 3'b010, 32'h900, 32'h8, 32'h0F1E2D3C, 5'd11, 1, 0, 32'h0, 1,
         busExp_t'{32'h908, 1'b1, 4'b1111, 32'h0F1E2D3C},
         respExp_t'{1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 2});

      @(negedge clock);
      checkOutput("busQEmpty", 32'(busQ.size()), 32'd0);
      checkOutput("respQEmpty", 32'(respQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   // Safety net so a stuck DUT can never hang the run.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got stuck expected finish");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule
